rom_prefetch: RTL and testbench

ROM_PREFETCH -- requirements
Module: rom_prefetch

---
 rtl/rom_prefetch_if.sv | 23 ++
 rtl/rom_prefetch.sv | 113 +++++++++++
 tb/tb_rom_prefetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rom_prefetch_if.sv
// rom_prefetch_if: CPU fetch request/response, flush and boot-ROM port of rom_prefetch.
interface rom_prefetch_if #(
  parameter int AW = 9
);
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          flush;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  modport master (
    output req_valid, req_addr, flush, rom_data,
    input  req_ready, resp_valid, resp_data, resp_err, rom_en, rom_addr
  );
  modport slave (
    input  req_valid, req_addr, flush, rom_data,
    output req_ready, resp_valid, resp_data, resp_err, rom_en, rom_addr
  );
endinterface

// File: rtl/rom_prefetch.sv
// rom_prefetch: two-entry word buffer with next-word prefetch in front of a boot ROM
// whose data is valid at the rising edge after a cycle with rom_en high.
module rom_prefetch #(
  parameter int AW = 9
) (
  input logic           clk,
  input logic           rst,
  rom_prefetch_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MISS_ISSUE, MISS_WAIT, PF_ISSUE, PF_WAIT} state_t;
  state_t             state_q;
  logic [1:0]         vld_q;
  logic [1:0][AW-1:0] tag_q;
  logic [1:0][31:0]   dat_q;
  logic               rr_q, pf_kill_q, ready_q, resp_valid_q, resp_err_q, rom_en_q;
  logic [31:0]        resp_data_q;
  logic [AW-1:0]      idx_q, rom_addr_q, idx, nxt;
  logic               fault, hit0, hit1, hit, nxt_hit, pf_ok;
  assign idx     = bus.req_addr[AW+1:2];
  assign fault   = |bus.req_addr[1:0] || |bus.req_addr[31:AW+2];
  assign hit0    = vld_q[0] && tag_q[0] == idx;
  assign hit1    = vld_q[1] && tag_q[1] == idx;
  // a flush coinciding with a request wins, so the request becomes a miss
  assign hit     = !bus.flush && (hit0 || hit1);
  assign nxt     = idx_q + AW'(1);
  assign nxt_hit = (vld_q[0] && tag_q[0] == nxt) || (vld_q[1] && tag_q[1] == nxt);
  assign pf_ok   = !pf_kill_q && !bus.flush && !(&idx_q) && !nxt_hit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      tag_q        <= '0;
      dat_q        <= '0;
      rr_q         <= 1'b0;
      pf_kill_q    <= 1'b0;
      idx_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      rom_en_q     <= 1'b0;
      if (bus.flush) vld_q <= '0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.req_valid && ready_q) begin
            if (fault) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else if (hit) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= hit0 ? dat_q[0] : dat_q[1];
            end else begin
              state_q    <= MISS_ISSUE;
              ready_q    <= 1'b0;
              rom_en_q   <= 1'b1;
              rom_addr_q <= idx;
              idx_q      <= idx;
              pf_kill_q  <= 1'b0;
            end
          end
        end
        MISS_ISSUE: begin
          state_q       <= MISS_WAIT;
          resp_valid_q  <= 1'b1;
          resp_err_q    <= 1'b0;
          resp_data_q   <= bus.rom_data;
          vld_q[rr_q]   <= 1'b1;
          tag_q[rr_q]   <= idx_q;
          dat_q[rr_q]   <= bus.rom_data;
          rr_q          <= ~rr_q;
          if (bus.flush) pf_kill_q <= 1'b1;
        end
        MISS_WAIT: begin
          if (pf_ok) begin
            state_q    <= PF_ISSUE;
            rom_en_q   <= 1'b1;
            rom_addr_q <= nxt;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        PF_ISSUE: begin
          state_q <= PF_WAIT;
          if (!bus.flush) begin
            vld_q[rr_q] <= 1'b1;
            tag_q[rr_q] <= rom_addr_q;
            dat_q[rr_q] <= bus.rom_data;
            rr_q        <= ~rr_q;
          end
        end
        PF_WAIT: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.rom_en     = rom_en_q;
  assign bus.rom_addr   = rom_addr_q;
endmodule

// File: tb/tb_rom_prefetch.sv
// tb_rom_prefetch: directed vector table for rom_prefetch plus reset corner sequences.
module tb_rom_prefetch;
  localparam int AW = 9;
  localparam int NONE = 9;
  typedef struct {
    logic [31:0]   addr;
    int            fc;
    bit            lat1;
    bit            err;
    logic [31:0]   data;
    bit            pf;
    logic [AW-1:0] pf_addr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs [18];
  rom_prefetch_if #(.AW(AW)) bus ();
  rom_prefetch #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return a == 0 ? 32'h0800_0101 : a == 1 ? 32'h0 : 32'hA500_0000 | 32'(a);
  endfunction
  initial bus.rom_data = '0;
  always @(negedge clk) if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, " resp_err"}, 32'(bus.resp_err), 0);
    chk({tag, " resp_data"}, bus.resp_data, 0);
    chk({tag, " rom_en"}, 32'(bus.rom_en), 0);
    chk({tag, " rom_addr"}, 32'(bus.rom_addr), 0);
  endtask
  task automatic run_vec(input int n, input vec_t v);
    int w = 0;
    logic [AW-1:0] idx = v.addr[AW+1:2];
    string s = $sformatf("v%0d", n);
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({s, " ready"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.flush     = v.fc == 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.flush     = v.fc == k;
      if (k == 1 && v.lat1) begin
        chk({s, " c1 resp_valid"}, 32'(bus.resp_valid), 1);
        chk({s, " c1 resp_err"}, 32'(bus.resp_err), 32'(v.err));
        chk({s, " c1 resp_data"}, bus.resp_data, v.data);
        chk({s, " c1 rom_en"}, 32'(bus.rom_en), 0);
      end else if (k == 1) begin
        chk({s, " c1 resp_valid"}, 32'(bus.resp_valid), 0);
        chk({s, " c1 rom_en"}, 32'(bus.rom_en), 1);
        chk({s, " c1 rom_addr"}, 32'(bus.rom_addr), 32'(idx));
      end else if (k == 2 && v.lat1) begin
        chk({s, " c2 resp_valid"}, 32'(bus.resp_valid), 0);
        chk({s, " c2 rom_en"}, 32'(bus.rom_en), 0);
      end else if (k == 2) begin
        chk({s, " c2 resp_valid"}, 32'(bus.resp_valid), 1);
        chk({s, " c2 resp_err"}, 32'(bus.resp_err), 0);
        chk({s, " c2 resp_data"}, bus.resp_data, v.data);
        chk({s, " c2 rom_en"}, 32'(bus.rom_en), 0);
      end else if (k == 3 && !v.lat1 && v.pf) begin
        chk({s, " c3 pf rom_en"}, 32'(bus.rom_en), 1);
        chk({s, " c3 pf rom_addr"}, 32'(bus.rom_addr), 32'(v.pf_addr));
        chk({s, " c3 resp_valid"}, 32'(bus.resp_valid), 0);
      end else if (k == 3) begin
        chk({s, " c3 rom_en"}, 32'(bus.rom_en), 0);
        chk({s, " c3 req_ready"}, 32'(bus.req_ready), 1);
      end else if (k == 4) begin
        chk({s, " c4 rom_en"}, 32'(bus.rom_en), 0);
        chk({s, " c4 resp_valid"}, 32'(bus.resp_valid), 0);
      end
    end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vecs = '{
      '{32'h000, NONE, 1'b0, 1'b0, 32'h0800_0101, 1'b1, 9'd1},
      '{32'h004, NONE, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 9'd0},
      '{32'h000, NONE, 1'b1, 1'b0, 32'h0800_0101, 1'b0, 9'd0},
      '{32'h006, NONE, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 9'd0},
      '{32'h800, NONE, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 9'd0},
      '{32'h7FC, NONE, 1'b0, 1'b0, 32'hA500_01FF, 1'b0, 9'd0},
      '{32'h7F8, NONE, 1'b0, 1'b0, 32'hA500_01FE, 1'b0, 9'd0},
      '{32'h008, NONE, 1'b0, 1'b0, 32'hA500_0002, 1'b1, 9'd3},
      '{32'h00C, NONE, 1'b1, 1'b0, 32'hA500_0003, 1'b0, 9'd0},
      '{32'h008, 0,    1'b0, 1'b0, 32'hA500_0002, 1'b1, 9'd3},
      '{32'h000, NONE, 1'b0, 1'b0, 32'h0800_0101, 1'b1, 9'd1},
      '{32'h020, 4,    1'b0, 1'b0, 32'hA500_0008, 1'b1, 9'd9},
      '{32'h024, NONE, 1'b0, 1'b0, 32'hA500_0009, 1'b1, 9'd10},
      '{32'h040, 1,    1'b0, 1'b0, 32'hA500_0010, 1'b0, 9'd0},
      '{32'h040, NONE, 1'b1, 1'b0, 32'hA500_0010, 1'b0, 9'd0},
      '{32'h044, NONE, 1'b0, 1'b0, 32'hA500_0011, 1'b1, 9'd18},
      '{32'h060, 3,    1'b0, 1'b0, 32'hA500_0018, 1'b1, 9'd25},
      '{32'h064, NONE, 1'b0, 1'b0, 32'hA500_0019, 1'b1, 9'd26}
    };
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b1;
    chk("por ready before edge", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("por ready after edge", 32'(bus.req_ready), 1);
    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);
    // reset in the middle of a miss: outputs clear at once, the read is dropped
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h80;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid resp_valid held", 32'(bus.resp_valid), 0);
      chk("mid rom_en held", 32'(bus.rom_en), 0);
    end
    rst = 1'b1;
    chk("mid ready before edge", 32'(bus.req_ready), 0);
    @(negedge clk);
    chk("mid ready after edge", 32'(bus.req_ready), 1);
    run_vec(100, vecs[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
